// File: rtl/token_req_agent.sv
// Requester-side endpoint of the token-ring req/ack handshake: queues jobs in a
// small FIFO and holds the grant for each job's beat count, flagging starvation and ack loss.
module token_req_agent #(
    parameter int DEPTH    = 4,
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         job_valid,
    input  logic [LEN_W-1:0]             job_len,
    output logic                         job_ready,
    input  logic                         ack,
    output logic                         req,
    output logic                         busy_beat,
    output logic                         job_done,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         starve,
    output logic                         proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, REQ, OWN, RELEASE} state_t;

    state_t             state;
    logic [LEN_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEN_W-1:0]   cnt;
    logic [7:0]         wait_cnt;
    logic [LEN_W-1:0]   head_len;
    logic               push;
    logic               pop;

    assign job_ready = (level < LVL_W'(DEPTH));
    assign push      = job_valid && job_ready;
    assign pop       = job_done;
    assign head_len  = mem[rd_ptr];

    assign req       = (state == REQ) || (state == OWN);
    assign busy_beat = (state == OWN);
    assign job_done  = (state == OWN) && (cnt == LEN_W'(1)) && ack;

    // NOTE: the job storage has no reset; entries are only read after being
    // written, and leaving them out of reset keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= job_len;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      level <= level + LVL_W'(1);
            else if (pop && !push) level <= level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wait_cnt  <= '0;
            starve    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (level != '0) state <= REQ;
                end
                REQ: begin
                    if (ack) begin
                        state    <= OWN;
                        wait_cnt <= '0;
                        // A non-zero count is a job resumed after lost ack.
                        if (cnt == '0) cnt <= (head_len == '0) ? LEN_W'(1) : head_len;
                    end else begin
                        if (wait_cnt < WAIT_MAX)              wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt >= WAIT_MAX - 8'd1)      starve   <= 1'b1;
                    end
                end
                OWN: begin
                    if (!ack) begin
                        proto_err <= 1'b1;
                        state     <= REQ;
                    end else if (cnt == LEN_W'(1)) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                RELEASE: begin
                    if (!ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
